// File: rtl/pic_bus_pkg.sv
// Shared types for the 8259A host-bus initiator: bus FSM states, A0 encodings,
// ICW1 bit positions and the auto-init step sequence.
package pic_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } bus_state_e;

  localparam logic A0_CMD  = 1'b0;
  localparam logic A0_DATA = 1'b1;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;

  typedef enum logic [2:0] {
    INIT_IDLE = 3'd0,
    INIT_ICW1 = 3'd1,
    INIT_ICW2 = 3'd2,
    INIT_ICW3 = 3'd3,
    INIT_ICW4 = 3'd4,
    INIT_WAIT = 3'd5
  } init_step_e;

  // ICW3 only exists in cascade mode, ICW4 only when ICW1 asks for it.
  function automatic init_step_e init_next_step(input init_step_e cur, input logic [7:0] icw1);
    init_step_e nxt;
    case (cur)
      INIT_ICW1: nxt = INIT_ICW2;
      INIT_ICW2: begin
        if (!icw1[ICW1_SNGL]) nxt = INIT_ICW3;
        else if (icw1[ICW1_IC4]) nxt = INIT_ICW4;
        else nxt = INIT_WAIT;
      end
      INIT_ICW3: begin
        if (icw1[ICW1_IC4]) nxt = INIT_ICW4;
        else nxt = INIT_WAIT;
      end
      default: nxt = INIT_WAIT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pic_init_sequencer.sv
// Issues the ICW1..ICW4 write requests into the bus master's request mux and
// reports completion; only instantiated when PIC_AUTO_INIT_EN is defined.
module pic_init_sequencer
  import pic_bus_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] icw1_i,
  input  logic [7:0] icw2_i,
  input  logic [7:0] icw3_i,
  input  logic [7:0] icw4_i,
  input  logic       accept_i,
  input  logic       xact_done_i,
  output logic       req_valid_o,
  output logic       req_a0_o,
  output logic [7:0] req_data_o,
  output logic       active_o,
  output logic       active_next_o,
  output logic       done_o
);

  init_step_e step_q, step_d;
  logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
  logic       done_q, done_d;

  always_comb begin
    step_d = step_q;
    icw1_d = icw1_q;
    icw2_d = icw2_q;
    icw3_d = icw3_q;
    icw4_d = icw4_q;
    done_d = 1'b0;
    case (step_q)
      INIT_IDLE: begin
        if (start_i) begin
          step_d = INIT_ICW1;
          icw1_d = icw1_i;
          icw2_d = icw2_i;
          icw3_d = icw3_i;
          icw4_d = icw4_i;
        end else begin
          step_d = INIT_IDLE;
        end
      end
      INIT_ICW1, INIT_ICW2, INIT_ICW3, INIT_ICW4: begin
        if (accept_i) step_d = init_next_step(step_q, icw1_q);
        else step_d = step_q;
      end
      INIT_WAIT: begin
        if (xact_done_i) begin
          step_d = INIT_IDLE;
          done_d = 1'b1;
        end else begin
          step_d = INIT_WAIT;
        end
      end
      default: step_d = INIT_IDLE;
    endcase
  end

  always_comb begin
    req_valid_o = 1'b1;
    req_a0_o    = A0_DATA;
    req_data_o  = 8'h00;
    case (step_q)
      INIT_ICW1: begin
        req_a0_o   = A0_CMD;
        req_data_o = icw1_q;
      end
      INIT_ICW2: req_data_o = icw2_q;
      INIT_ICW3: req_data_o = icw3_q;
      INIT_ICW4: req_data_o = icw4_q;
      default:   req_valid_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      step_q <= INIT_IDLE;
      icw1_q <= 8'h00;
      icw2_q <= 8'h00;
      icw3_q <= 8'h00;
      icw4_q <= 8'h00;
      done_q <= 1'b0;
    end else begin
      step_q <= step_d;
      icw1_q <= icw1_d;
      icw2_q <= icw2_d;
      icw3_q <= icw3_d;
      icw4_q <= icw4_d;
      done_q <= done_d;
    end
  end

  assign active_o      = (step_q != INIT_IDLE);
  assign active_next_o = (step_d != INIT_IDLE);
  assign done_o        = done_q;

endmodule

// File: rtl/pic_bus_master.sv
// Converts a valid/ready command stream into 8259A CS/RD/WR/A0/data strobe sequences.
// Optional ICW auto-initialisation is enabled by defining PIC_AUTO_INIT_EN.
module pic_bus_master
  import pic_bus_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rd_i,
  input  logic       req_a0_i,
  input  logic [7:0] req_data_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       busy_o,
  output logic       cs_o,
  output logic       read_o,
  output logic       write_o,
  output logic       a0_o,
  output logic [7:0] data_out_o,
  output logic       data_oe_o,
  input  logic [7:0] data_in_i
`ifdef PIC_AUTO_INIT_EN
  ,
  input  logic       init_start_i,
  input  logic [7:0] icw1_i,
  input  logic [7:0] icw2_i,
  input  logic [7:0] icw3_i,
  input  logic [7:0] icw4_i,
  output logic       init_done_o
`endif
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_param_check
    $error("pic_bus_master: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
  end

  bus_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lat_rd_q, lat_rd_d, lat_a0_q, lat_a0_d;
  logic [7:0]       lat_data_q, lat_data_d;
  logic             req_ready_q, req_ready_d, busy_q, busy_d;
  logic             cs_q, cs_d, read_q, read_d, write_q, write_d, a0_out_q, a0_out_d;
  logic [7:0]       data_out_q, data_out_d, rsp_data_q, rsp_data_d;
  logic             data_oe_q, data_oe_d, rsp_valid_q, rsp_valid_d;

  logic       src_valid_s, src_rd_s, src_a0_s, accept_s, xact_done_s;
  logic [7:0] src_data_s;
  logic       init_active_s, init_active_next_s;

  assign accept_s    = (state_q == ST_IDLE) & src_valid_s;
  assign xact_done_s = (state_q == ST_HOLD) & (cnt_q == '0);

`ifdef PIC_AUTO_INIT_EN
  logic       ext_accept_s, init_launch_s, seq_valid_s, seq_a0_s;
  logic [7:0] seq_data_s;

  // An external handshake already granted this cycle wins over a same-cycle init_start.
  assign ext_accept_s  = req_valid_i & req_ready_q;
  assign init_launch_s = init_start_i & ~busy_q & ~ext_accept_s;

  pic_init_sequencer u_init_seq (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .start_i       (init_launch_s),
    .icw1_i        (icw1_i),
    .icw2_i        (icw2_i),
    .icw3_i        (icw3_i),
    .icw4_i        (icw4_i),
    .accept_i      (accept_s & init_active_s),
    .xact_done_i   (xact_done_s),
    .req_valid_o   (seq_valid_s),
    .req_a0_o      (seq_a0_s),
    .req_data_o    (seq_data_s),
    .active_o      (init_active_s),
    .active_next_o (init_active_next_s),
    .done_o        (init_done_o)
  );

  assign src_valid_s = init_active_s ? seq_valid_s : ext_accept_s;
  assign src_rd_s    = init_active_s ? 1'b0 : req_rd_i;
  assign src_a0_s    = init_active_s ? seq_a0_s : req_a0_i;
  assign src_data_s  = init_active_s ? seq_data_s : req_data_i;
`else
  assign init_active_s      = 1'b0;
  assign init_active_next_s = 1'b0;
  assign src_valid_s        = req_valid_i & req_ready_q;
  assign src_rd_s           = req_rd_i;
  assign src_a0_s           = req_a0_i;
  assign src_data_s         = req_data_i;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_rd_d    = lat_rd_q;
    lat_a0_d    = lat_a0_q;
    lat_data_d  = lat_data_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d    = ST_SETUP;
          cnt_d      = SETUP_LOAD;
          lat_rd_d   = src_rd_s;
          lat_a0_d   = src_a0_s;
          lat_data_d = src_data_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = PULSE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
          if (lat_rd_q) rsp_data_d = data_in_i;
          else rsp_data_d = rsp_data_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d     = ST_IDLE;
          rsp_valid_d = lat_rd_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus pins are registered from the next state so they change cleanly on one edge.
  always_comb begin
    cs_d        = (state_d == ST_IDLE);
    read_d      = ~((state_d == ST_STROBE) & lat_rd_d);
    write_d     = ~((state_d == ST_STROBE) & ~lat_rd_d);
    req_ready_d = (state_d == ST_IDLE) & ~init_active_next_s;
    busy_d      = ~req_ready_d;
    if (!cs_d) begin
      a0_out_d   = lat_a0_d;
      data_oe_d  = ~lat_rd_d;
      data_out_d = lat_rd_d ? 8'h00 : lat_data_d;
    end else begin
      a0_out_d   = 1'b0;
      data_oe_d  = 1'b0;
      data_out_d = 8'h00;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lat_rd_q    <= 1'b0;
      lat_a0_q    <= 1'b0;
      lat_data_q  <= 8'h00;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      cs_q        <= 1'b1;
      read_q      <= 1'b1;
      write_q     <= 1'b1;
      a0_out_q    <= 1'b0;
      data_out_q  <= 8'h00;
      data_oe_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_rd_q    <= lat_rd_d;
      lat_a0_q    <= lat_a0_d;
      lat_data_q  <= lat_data_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      cs_q        <= cs_d;
      read_q      <= read_d;
      write_q     <= write_d;
      a0_out_q    <= a0_out_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign busy_o      = busy_q;
  assign cs_o        = cs_q;
  assign read_o      = read_q;
  assign write_o     = write_q;
  assign a0_o        = a0_out_q;
  assign data_out_o  = data_out_q;
  assign data_oe_o   = data_oe_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_pic_bus_master.sv
// Scoreboard bench for pic_bus_master: expected bus transactions and read
// responses are queued at request time and checked by a negedge bus monitor.
module tb_pic_bus_master;

  localparam int SETUP_CYC = 1;
  localparam int PULSE_CYC = 2;
  localparam int HOLD_CYC  = 1;
  localparam int TXN_LEN   = 4;
  localparam int STB_POS   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_i = 1'b1;
  logic       req_valid_i = 1'b0, req_rd_i = 1'b0, req_a0_i = 1'b0;
  logic [7:0] req_data_i = 8'h00, data_in_i = 8'h00;
  logic       req_ready_o, rsp_valid_o, busy_o, cs_o, read_o, write_o, a0_o, data_oe_o;
  logic [7:0] rsp_data_o, data_out_o;
`ifdef PIC_AUTO_INIT_EN
  logic       init_start_i = 1'b0;
  logic [7:0] icw1_i = 8'h00, icw2_i = 8'h00, icw3_i = 8'h00, icw4_i = 8'h00;
  logic       init_done_o;
`endif

  pic_bus_master #(.SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .HOLD_CYC(HOLD_CYC)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rd_i(req_rd_i), .req_a0_i(req_a0_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .busy_o(busy_o),
    .cs_o(cs_o), .read_o(read_o), .write_o(write_o), .a0_o(a0_o),
    .data_out_o(data_out_o), .data_oe_o(data_oe_o), .data_in_i(data_in_i)
`ifdef PIC_AUTO_INIT_EN
    , .init_start_i(init_start_i), .icw1_i(icw1_i), .icw2_i(icw2_i),
    .icw3_i(icw3_i), .icw4_i(icw4_i), .init_done_o(init_done_o)
`endif
  );

  typedef struct packed {
    logic       init;
    logic       rd;
    logic       a0;
    logic [7:0] data;
  } txn_t;

  txn_t       exp_txn_q[$];
  logic [7:0] exp_rsp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Bus monitor state
  logic       cs_prev = 1'b1, wr_prev = 1'b1, rd_prev = 1'b1, a0_prev = 1'b0, oe_prev = 1'b0;
  logic [7:0] dout_prev = 8'h00;
  int         cs_len = 0, wr_len = 0, rdl_len = 0, falls = 0, st_pos = 0, done_cnt = 0;
  logic       bad = 1'b0, aborted = 1'b0, a0_first = 1'b0, oe_first = 1'b0;
  logic [7:0] d_first = 8'h00;
  time        last_done_t = 0, last_acc_t = 0;

  always @(negedge clk) begin : monitor
    txn_t t;
    if (reset_i && !cs_o) aborted = 1'b1;
    if (!cs_o) begin
      if (cs_prev) begin
        cs_len = 0; wr_len = 0; rdl_len = 0; falls = 0; st_pos = 0; bad = 1'b0;
        a0_first = a0_o; d_first = data_out_o; oe_first = data_oe_o;
      end
      cs_len++;
      if (!write_o) wr_len++;
      if (!read_o) rdl_len++;
      if ((!write_o && wr_prev) || (!read_o && rd_prev)) begin
        if (falls == 0) st_pos = cs_len;
        falls++;
      end
      if (!write_o && !read_o) bad = 1'b1;
      if (!cs_prev && (a0_o !== a0_prev || data_out_o !== dout_prev || data_oe_o !== oe_prev)) bad = 1'b1;
    end else if (!cs_prev) begin
      check_eq("txn_expected", 32'(exp_txn_q.size() != 0), 32'd1);
      if (exp_txn_q.size() != 0) begin
        t = exp_txn_q.pop_front();
        if (!aborted) begin
          check_eq("cs_low_len", 32'(cs_len), 32'(TXN_LEN));
          check_eq("strobe_len", 32'(t.rd ? rdl_len : wr_len), 32'(PULSE_CYC));
          check_eq("other_strobe_len", 32'(t.rd ? wr_len : rdl_len), 32'd0);
          check_eq("strobe_falls", 32'(falls), 32'd1);
          check_eq("strobe_pos", 32'(st_pos), 32'(STB_POS));
          check_eq("a0", 32'(a0_first), 32'(t.a0));
          check_eq("data_oe", 32'(oe_first), 32'(!t.rd));
          if (!t.rd) check_eq("wdata", 32'(d_first), 32'(t.data));
          check_eq("bus_stable", 32'(bad), 32'd0);
          if (!t.init) check_eq("ready_at_idle", 32'(req_ready_o), 32'd1);
        end
      end
      aborted = 1'b0;
    end
    if (rsp_valid_o) begin
      check_eq("rsp_expected", 32'(exp_rsp_q.size() != 0), 32'd1);
      if (exp_rsp_q.size() != 0) check_eq("rsp_data", 32'(rsp_data_o), 32'(exp_rsp_q.pop_front()));
    end
`ifdef PIC_AUTO_INIT_EN
    if (init_done_o) begin
      done_cnt++;
      last_done_t = $time;
    end
`endif
    cs_prev = cs_o; wr_prev = write_o; rd_prev = read_o;
    a0_prev = a0_o; dout_prev = data_out_o; oe_prev = data_oe_o;
  end

  // Called just after a posedge; returns just after the posedge that accepted the request.
  task automatic send(input logic rd, input logic a0, input logic [7:0] data, input logic want_rsp);
    int   n;
    txn_t t;
    req_valid_i = 1'b1; req_rd_i = rd; req_a0_i = a0; req_data_i = data;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready_o && n < 300);
    check_eq("accept", 32'(req_ready_o), 32'd1);
    if (req_ready_o) begin
      t.init = 1'b0; t.rd = rd; t.a0 = a0; t.data = data;
      exp_txn_q.push_back(t);
      if (rd && want_rsp) exp_rsp_q.push_back(data_in_i);
      last_acc_t = $time;
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_txn_q.size() != 0 || exp_rsp_q.size() != 0 || busy_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(n < 300), 32'd1);
    @(posedge clk); #1;
  endtask

`ifdef PIC_AUTO_INIT_EN
  task automatic push_init(input logic a0, input logic [7:0] data);
    txn_t t;
    t.init = 1'b1; t.rd = 1'b0; t.a0 = a0; t.data = data;
    exp_txn_q.push_back(t);
  endtask
`endif

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic       r_rd, r_a0;
  logic [7:0] r_d;
  int         n;

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready_o), 32'd1);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_cs", 32'(cs_o), 32'd1);
    check_eq("rst_read", 32'(read_o), 32'd1);
    check_eq("rst_write", 32'(write_o), 32'd1);
    check_eq("rst_a0", 32'(a0_o), 32'd0);
    check_eq("rst_dout", 32'(data_out_o), 32'd0);
    check_eq("rst_oe", 32'(data_oe_o), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data_o), 32'd0);
    @(posedge clk); #1;
    reset_i = 1'b0;

    send(1'b0, 1'b0, 8'h13, 1'b0);
    drain();
    data_in_i = 8'hA5;
    send(1'b1, 1'b1, 8'h00, 1'b1);
    drain();
    send(1'b0, 1'b1, 8'h20, 1'b0);
    send(1'b0, 1'b1, 8'hFE, 1'b0);
    drain();

    for (int i = 0; i < 8; i++) begin
      r_rd = 1'($urandom_range(0, 1));
      r_a0 = 1'($urandom_range(0, 1));
      r_d  = 8'($urandom_range(0, 255));
      data_in_i = 8'($urandom_range(0, 255));
      send(r_rd, r_a0, r_d, 1'b1);
      drain();
    end

    // Abort a read in its strobe phase with a synchronous reset.
    data_in_i = 8'h3C;
    send(1'b1, 1'b0, 8'h00, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (read_o && n < 50);
    check_eq("reach_strobe", 32'(read_o), 32'd0);
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_cs", 32'(cs_o), 32'd1);
    check_eq("abort_read", 32'(read_o), 32'd1);
    check_eq("abort_write", 32'(write_o), 32'd1);
    check_eq("abort_oe", 32'(data_oe_o), 32'd0);
    check_eq("abort_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check_eq("abort_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    check_eq("abort_no_rsp", 32'(rsp_valid_o), 32'd0);
    @(posedge clk); #1;
    send(1'b0, 1'b0, 8'h5A, 1'b0);
    drain();

`ifdef PIC_AUTO_INIT_EN
    icw1_i = 8'h13; icw2_i = 8'h20; icw3_i = 8'hAA; icw4_i = 8'h01;
    push_init(1'b0, 8'h13); push_init(1'b1, 8'h20); push_init(1'b1, 8'h01);
    init_start_i = 1'b1;
    @(posedge clk); #1;
    init_start_i = 1'b0;
    icw2_i = 8'h77;
    drain();
    check_eq("init_done_cnt1", 32'(done_cnt), 32'd1);

    icw1_i = 8'h11; icw2_i = 8'h28; icw3_i = 8'h04; icw4_i = 8'h01;
    push_init(1'b0, 8'h11); push_init(1'b1, 8'h28); push_init(1'b1, 8'h04); push_init(1'b1, 8'h01);
    init_start_i = 1'b1;
    @(posedge clk); #1;
    init_start_i = 1'b0;
    send(1'b0, 1'b1, 8'h55, 1'b0);
    check_eq("init_done_cnt2", 32'(done_cnt), 32'd2);
    check_eq("acc_after_done", 32'(last_acc_t >= last_done_t), 32'd1);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
